// File: rtl/chu_vga_collision_core_if.sv
// Register-slot bus for the VGA collision core.
//   cs      : slot select
//   read    : read strobe (one-cycle registered read data)
//   write   : write strobe
//   addr    : register address, low three bits decoded by the core
//   wr_data : write data
//   rd_data : registered read data returned by the core
interface chu_vga_collision_core_if;
  logic        cs;
  logic        read;
  logic        write;
  logic [13:0] addr;
  logic [31:0] wr_data;
  logic [31:0] rd_data;

  modport master (output cs, read, write, addr, wr_data, input rd_data);
  modport slave  (input cs, read, write, addr, wr_data, output rd_data);
endinterface

// File: rtl/chu_vga_collision_core.sv
// VGA collision core: passes the pixel stream through untouched and counts,
// per frame, the pixels inside a programmable window whose color equals a
// target color. At every frame start (pixel 0,0) the live count and the first
// hit coordinate are snapshotted, sticky done/collide flags are set and a
// 16-bit frame counter advances.
//   clk     : clock
//   reset   : asynchronous active-high reset
//   x, y    : current pixel coordinate from the frame counter
//   bus     : register slot (ctrl, target, window bounds; status readback)
//   si_rgb  : upstream pixel stream
//   so_rgb  : downstream pixel stream (combinational copy of si_rgb)
module chu_vga_collision_core #(
  parameter int CD    = 12,
  parameter int CNT_W = 20
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [10:0]              x,
  input  logic [10:0]              y,
  chu_vga_collision_core_if.slave  bus,
  input  logic [CD-1:0]            si_rgb,
  output logic [CD-1:0]            so_rgb
);

  logic             r_enable;
  logic [CD-1:0]    r_target;
  logic [10:0]      r_xlo, r_xhi, r_ylo, r_yhi;
  logic [21:0]      r_prev_xy;
  logic [CNT_W-1:0] r_live_cnt, r_last_cnt;
  logic [22:0]      r_live_first, r_last_first;
  logic             r_frame_done, r_collide;
  logic [15:0]      r_frame_cnt;
  logic [31:0]      r_rd_data;

  logic             w_pix;
  logic             w_frame_start;
  logic             w_hit;
  logic             w_wr, w_rd, w_clr;
  logic             w_live_max;
  logic [31:0]      w_rd_word;
  logic             w_unused;

  assign so_rgb = si_rgb;

  // A coordinate held over several clocks is one pixel: only a change of
  // {x,y} against last cycle's value strobes the pixel logic.
  assign w_pix         = ({x, y} != r_prev_xy);
  assign w_frame_start = w_pix && (x == 11'd0) && (y == 11'd0);
  assign w_hit         = w_pix && r_enable && (si_rgb == r_target) &&
                         (x >= r_xlo) && (x <= r_xhi) &&
                         (y >= r_ylo) && (y <= r_yhi);

  assign w_wr       = bus.cs && bus.write;
  assign w_rd       = bus.cs && bus.read;
  assign w_clr      = w_wr && (bus.addr[2:0] == 3'd0) && bus.wr_data[1];
  assign w_live_max = (r_live_cnt == {CNT_W{1'b1}});

  // Upper address bits and unused data bits are intentionally ignored.
  assign w_unused = ^{bus.addr[13:3], bus.wr_data};

  always_comb begin
    w_rd_word = 32'd0;
    case (bus.addr[2:0])
      3'd0:    w_rd_word = {14'd0, r_collide, r_frame_done, r_frame_cnt};
      3'd1:    w_rd_word = 32'(r_last_cnt);
      3'd2:    w_rd_word = {9'd0, r_last_first};
      3'd3:    w_rd_word = 32'(r_target);
      default: w_rd_word = 32'd0;
    endcase
  end

  assign bus.rd_data = r_rd_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_enable     <= 1'b0;
      r_target     <= '0;
      r_xlo        <= '0;
      r_xhi        <= '0;
      r_ylo        <= '0;
      r_yhi        <= '0;
      r_prev_xy    <= '0;
      r_live_cnt   <= '0;
      r_last_cnt   <= '0;
      r_live_first <= '0;
      r_last_first <= '0;
      r_frame_done <= 1'b0;
      r_collide    <= 1'b0;
      r_frame_cnt  <= '0;
      r_rd_data    <= '0;
    end else begin
      r_prev_xy <= {x, y};

      if (w_frame_start) begin
        r_last_cnt   <= r_live_cnt;
        r_last_first <= r_live_first;
        r_frame_cnt  <= r_frame_cnt + 16'd1;
        // Pixel (0,0) belongs to the new frame, so it seeds the live state.
        r_live_cnt   <= w_hit ? CNT_W'(1) : '0;
        r_live_first <= w_hit ? {1'b1, y, x} : '0;
      end else if (w_hit) begin
        if (!w_live_max)
          r_live_cnt <= r_live_cnt + CNT_W'(1);
        if (!r_live_first[22])
          r_live_first <= {1'b1, y, x};
      end

      // Frame start setting a flag wins over a same-cycle clear.
      if (w_frame_start)
        r_frame_done <= 1'b1;
      else if (w_clr)
        r_frame_done <= 1'b0;

      if (w_frame_start && (r_live_cnt != '0))
        r_collide <= 1'b1;
      else if (w_clr)
        r_collide <= 1'b0;

      if (w_wr) begin
        case (bus.addr[2:0])
          3'd0:    r_enable <= bus.wr_data[0];
          3'd1:    r_target <= bus.wr_data[CD-1:0];
          3'd2:    r_xlo    <= bus.wr_data[10:0];
          3'd3:    r_xhi    <= bus.wr_data[10:0];
          3'd4:    r_ylo    <= bus.wr_data[10:0];
          3'd5:    r_yhi    <= bus.wr_data[10:0];
          default: ;
        endcase
      end

      // Read samples pre-edge register values, so a same-cycle write is
      // not visible until the next read.
      if (w_rd)
        r_rd_data <= w_rd_word;
    end
  end

endmodule

// File: tb/tb_chu_vga_collision_core.sv
module tb_chu_vga_collision_core;
  localparam int CD = 12;
  localparam logic [11:0] RED = 12'hF00;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [10:0]   x = '0;
  logic [10:0]   y = '0;
  logic [CD-1:0] si_rgb = '0;
  logic [CD-1:0] so_a, so_b;
  bit            go = 1'b0;

  chu_vga_collision_core_if if_a ();
  chu_vga_collision_core_if if_b ();

  chu_vga_collision_core #(.CD(CD), .CNT_W(20)) dut_a (
    .clk(clk), .reset(reset), .x(x), .y(y), .bus(if_a), .si_rgb(si_rgb), .so_rgb(so_a));

  chu_vga_collision_core #(.CD(CD), .CNT_W(4)) dut_b (
    .clk(clk), .reset(reset), .x(x), .y(y), .bus(if_b), .si_rgb(si_rgb), .so_rgb(so_b));

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  // ---------------- behavioural model ----------------
  logic          m_en = 0;
  logic [CD-1:0] m_tgt = 0;
  logic [10:0]   m_xlo = 0, m_xhi = 0, m_ylo = 0, m_yhi = 0;
  logic [10:0]   m_px = 0, m_py = 0;
  int            m_live = 0;     // hits so far this frame, unbounded
  logic [22:0]   m_first = 0;
  int            m_last = 0;
  logic [22:0]   m_lfirst = 0;
  logic          m_done = 0, m_coll = 0;
  int            m_frames = 0;
  logic [31:0]   m_rd_a = 0, m_rd_b = 0;

  function automatic logic [31:0] word(logic [2:0] a, int w);
    longint sat;
    sat = (64'd1 << w) - 1;
    case (a)
      3'd0:    word = {14'd0, m_coll, m_done, 16'(m_frames % 65536)};
      3'd1:    word = (longint'(m_last) > sat) ? 32'(sat) : 32'(m_last);
      3'd2:    word = {9'd0, m_lfirst};
      3'd3:    word = 32'(m_tgt);
      default: word = 32'd0;
    endcase
  endfunction

  task automatic model_step();
    bit strobe, fs, hit, clr;
    logic [2:0]  a;
    logic [31:0] d;
    if (reset) begin
      m_en = 0; m_tgt = 0; m_xlo = 0; m_xhi = 0; m_ylo = 0; m_yhi = 0;
      m_px = 0; m_py = 0; m_live = 0; m_first = 0; m_last = 0; m_lfirst = 0;
      m_done = 0; m_coll = 0; m_frames = 0; m_rd_a = 0; m_rd_b = 0;
      return;
    end
    a = if_a.addr[2:0];
    d = if_a.wr_data;
    strobe = (x != m_px) || (y != m_py);
    fs  = strobe && (x == 0) && (y == 0);
    hit = strobe && m_en && (si_rgb == m_tgt) &&
          (x >= m_xlo) && (x <= m_xhi) && (y >= m_ylo) && (y <= m_yhi);
    clr = if_a.cs && if_a.write && (a == 3'd0) && d[1];
    if (if_a.cs && if_a.read) begin
      m_rd_a = word(a, 20);
      m_rd_b = word(a, 4);
    end
    if (fs) begin
      m_coll   = (m_live != 0) ? 1'b1 : (clr ? 1'b0 : m_coll);
      m_done   = 1'b1;
      m_last   = m_live;
      m_lfirst = m_first;
      m_frames++;
      m_live   = 0;
      m_first  = 0;
    end else if (clr) begin
      m_done = 0;
      m_coll = 0;
    end
    if (hit) begin
      if (m_live == 0) m_first = {1'b1, y, x};
      m_live++;
    end
    if (if_a.cs && if_a.write) begin
      case (a)
        3'd0: m_en  = d[0];
        3'd1: m_tgt = d[CD-1:0];
        3'd2: m_xlo = d[10:0];
        3'd3: m_xhi = d[10:0];
        3'd4: m_ylo = d[10:0];
        3'd5: m_yhi = d[10:0];
        default: ;
      endcase
    end
    m_px = x;
    m_py = y;
  endtask

  always @(posedge clk) model_step();

  // ---------------- per-cycle compare ----------------
  initial begin
    forever begin
      @(negedge clk);
      if (go) begin
        check("rd_data_w20", if_a.rd_data, m_rd_a);
        check("rd_data_w4", if_b.rd_data, m_rd_b);
        check("so_rgb_a", 32'(so_a), 32'(si_rgb));
        check("so_rgb_b", 32'(so_b), 32'(si_rgb));
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic bus_set(bit c, bit r, bit w, logic [13:0] a, logic [31:0] d);
    if_a.cs = c; if_a.read = r; if_a.write = w; if_a.addr = a; if_a.wr_data = d;
    if_b.cs = c; if_b.read = r; if_b.write = w; if_b.addr = a; if_b.wr_data = d;
  endtask

  task automatic wr(logic [13:0] a, logic [31:0] d);
    bus_set(1, 0, 1, a, d);
    step();
    bus_set(0, 0, 0, 0, 0);
    $display("wr addr=%0d data=0x%08h", a, d);
  endtask

  task automatic rd(logic [13:0] a, output logic [31:0] ra, output logic [31:0] rb);
    bus_set(1, 1, 0, a, 0);
    step();
    ra = if_a.rd_data;
    rb = if_b.rd_data;
    bus_set(0, 0, 0, 0, 0);
    $display("rd addr=%0d data_w20=0x%08h data_w4=0x%08h", a, ra, rb);
  endtask

  task automatic rw(logic [13:0] a, logic [31:0] d, output logic [31:0] ra, output logic [31:0] rb);
    bus_set(1, 1, 1, a, d);
    step();
    ra = if_a.rd_data;
    rb = if_b.rd_data;
    bus_set(0, 0, 0, 0, 0);
    $display("rw addr=%0d wdata=0x%08h rdata_w20=0x%08h rdata_w4=0x%08h", a, d, ra, rb);
  endtask

  task automatic pix(int px, int py, logic [CD-1:0] rgb, int hold);
    x = 11'(px); y = 11'(py); si_rgb = rgb;
    repeat (hold) step();
  endtask

  task automatic red_frame();
    for (int yy = 50; yy <= 52; yy++)
      for (int xx = 100; xx <= 103; xx++)
        pix(xx, yy, RED, 1);
  endtask

  task automatic std_cfg();
    wr(1, 32'(RED)); wr(2, 100); wr(3, 109); wr(4, 50); wr(5, 51); wr(0, 1);
  endtask

  logic [31:0] ra, rb;
  int          op;
  logic [13:0] ra_addr;
  logic [31:0] rnd_d;
  localparam logic [31:0] FIRST_100_50 = (32'd1 << 22) | (32'd50 << 11) | 32'd100;

  initial begin
    bus_set(0, 0, 0, 0, 0);
    reset = 1'b1;
    repeat (2) step();
    reset = 1'b0;
    go = 1'b1;
    step();

    // reset state
    rd(0, ra, rb); check("reset_status", ra, 32'h0);
    rd(3, ra, rb); check("reset_target", ra, 32'h0);

    // basic 4x3 red block, window clips to 2 rows
    std_cfg();
    red_frame();
    pix(0, 0, 0, 1);
    rd(1, ra, rb); check("basic_last_cnt", ra, 32'd8); check("basic_last_cnt_w4", rb, 32'd8);
    rd(2, ra, rb); check("basic_last_first", ra, FIRST_100_50);
    rd(0, ra, rb); check("basic_status", ra, 32'h0003_0001);
    rd(3, ra, rb); check("basic_target", ra, 32'h0000_0F00);

    // held coordinates count once per pixel
    pix(100, 50, RED, 4); pix(101, 50, RED, 4); pix(102, 51, RED, 4);
    pix(0, 0, 0, 4);
    rd(1, ra, rb); check("held_last_cnt", ra, 32'd3);

    // enable off
    wr(0, 2);
    red_frame();
    pix(0, 0, 0, 1);
    rd(1, ra, rb); check("disabled_last_cnt", ra, 32'd0);
    rd(2, ra, rb); check("disabled_last_first", ra, 32'd0);
    rd(0, ra, rb); check("disabled_status", ra, 32'h0001_0003);

    // inverted x window
    wr(2, 10); wr(3, 5); wr(0, 3);
    red_frame();
    pix(0, 0, 0, 1);
    rd(1, ra, rb); check("inverted_last_cnt", ra, 32'd0);
    rd(0, ra, rb); check("inverted_status", ra, 32'h0001_0004);
    wr(2, 100); wr(3, 109);

    // clear coinciding with frame start: set wins; next clear works
    red_frame();
    x = 0; y = 0; si_rgb = 0;
    wr(0, 3);
    rw(0, 3, ra, rb); check("set_wins_status", ra, 32'h0003_0005);
    rd(0, ra, rb); check("cleared_status", ra, 32'h0000_0005);

    // saturation: 20 hits
    for (int yy = 50; yy <= 51; yy++)
      for (int xx = 100; xx <= 109; xx++)
        pix(xx, yy, RED, 1);
    pix(0, 0, 0, 1);
    rd(1, ra, rb); check("sat_last_cnt_w20", ra, 32'd20); check("sat_last_cnt_w4", rb, 32'd15);

    // randomized frames checked by the model every cycle
    for (int f = 0; f < 10; f++) begin
      wr(2, (f % 3 == 0) ? 0 : 95 + $urandom % 12);
      wr(3, 95 + $urandom % 12);
      wr(4, (f % 3 == 0) ? 0 : 47 + $urandom % 4);
      wr(5, 47 + $urandom % 5);
      wr(0, {30'd0, 1'($urandom % 2), 1'(($urandom % 4) != 0)});
      for (int p = 0; p < 30; p++) begin
        x = 11'(92 + $urandom % 22);
        y = 11'(46 + $urandom % 7);
        si_rgb = (($urandom % 3) != 0) ? RED : CD'($urandom);
        op = int'($urandom % 6);
        ra_addr = 14'($urandom);
        rnd_d = $urandom;
        case (op)
          0: bus_set(1, 1, 0, ra_addr, 0);
          1: bus_set(1, 0, 1, {ra_addr[13:1], 1'b1} | 14'd6, rnd_d);
          2: bus_set(1, 1, 1, {ra_addr[13:3], 3'd0}, {30'd0, rnd_d[1], 1'b1});
          default: bus_set(0, 0, 0, 0, 0);
        endcase
        if (op <= 2) $display("rnd op=%0d addr=0x%04h data=0x%08h", op, if_a.addr, if_a.wr_data);
        step();
        bus_set(0, 0, 0, 0, 0);
        repeat ($urandom % 3) step();
      end
      pix(0, 0, (f % 3 == 0) ? RED : 12'h000, 1);
      rd(1, ra, rb);
      rd(2, ra, rb);
      rd(0, ra, rb);
    end

    // reset mid-frame
    std_cfg();
    for (int xx = 100; xx <= 104; xx++) pix(xx, 50, RED, 1);
    rd(3, ra, rb);
    reset = 1'b1;
    #1;
    check("rd_in_reset_w20", if_a.rd_data, 32'd0);
    check("rd_in_reset_w4", if_b.rd_data, 32'd0);
    for (int i = 0; i < 3; i++) begin
      si_rgb = CD'($urandom);
      step();
    end
    reset = 1'b0;
    step();
    std_cfg();
    pix(106, 50, RED, 1); pix(107, 50, RED, 1);
    pix(0, 0, 0, 1);
    rd(1, ra, rb); check("post_reset_last_cnt", ra, 32'd2);
    rd(0, ra, rb); check("post_reset_status", ra, 32'h0003_0001);

    // frame counter wrap
    for (int i = 0; i < 65534; i++) begin
      x = 1; step();
      x = 0; step();
    end
    rd(0, ra, rb); check("frame_cnt_ffff", ra, 32'h0003_FFFF);
    x = 1; step();
    x = 0; step();
    rd(0, ra, rb); check("frame_cnt_wrap", ra, 32'h0003_0000);

    go = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
